// File: rtl/fifo_pack_writer_pkg.sv
// Field layout shared by the FIFO write-side packer and the read-side unpacker.
// A packed word is {last, cnt_m1, lanes} with lane 0 at the LSBs.
package fifo_pack_pkg;

    localparam int DATA_LSB = 0;

    function automatic int calc_cw(input int ratio);
        return $clog2(ratio);
    endfunction

    function automatic int cnt_lsb(input int in_width, input int ratio);
        return in_width * ratio;
    endfunction

    function automatic int last_bit(input int in_width, input int ratio);
        return cnt_lsb(in_width, ratio) + calc_cw(ratio);
    endfunction

    function automatic int word_width(input int in_width, input int ratio);
        return last_bit(in_width, ratio) + 1;
    endfunction

endpackage

// File: rtl/fifo_pack_writer_if.sv
// Byte-lane input stream plus FIFO write port of the packer.
// The master side owns the stream data and the FIFO almost-full.
interface fifo_pack_writer_if
    import fifo_pack_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    localparam int WW = word_width(IN_WIDTH, RATIO);

    logic [IN_WIDTH-1:0] in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic                flush;
    logic [WW-1:0]       wr_data;
    logic                we;
    logic                full;

    modport master (
        output in_data, in_valid, in_last, flush, full,
        input  in_ready, wr_data, we
    );

    modport slave (
        input  in_data, in_valid, in_last, flush, full,
        output in_ready, wr_data, we
    );

endinterface

// File: rtl/fifo_pack_writer.sv
// Gathers up to RATIO input lanes into one FIFO word; partial words leave on
// packet end, explicit flush or idle timeout.
module fifo_pack_writer
    import fifo_pack_pkg::*;
#(
    parameter int          IN_WIDTH = 8,
    parameter int          RATIO    = 4,
    parameter logic [15:0] TIMEOUT  = 16'd0
) (
    input  logic              clk,
    input  logic              reset_l,
    fifo_pack_writer_if.slave bus
);

    localparam int              CW        = calc_cw(RATIO);
    localparam int              DW        = RATIO * IN_WIDTH;
    localparam int              WW        = word_width(IN_WIDTH, RATIO);
    localparam int              LAST_BIT  = last_bit(IN_WIDTH, RATIO);
    localparam int              CNT_LSB   = cnt_lsb(IN_WIDTH, RATIO);
    localparam logic [CW-1:0]   LANE_MAX  = CW'(RATIO - 1);
    localparam logic [CW-1:0]   LANE_ZERO = {CW{1'b0}};

    logic [CW-1:0] lane_r;
    logic [DW-1:0] hold_r;
    logic [15:0]   timer_r;
    logic          flush_pend_r;
    logic          we_r;
    logic [WW-1:0] wr_data_r;

    logic          accept_s;
    logic          complete_s;
    logic          timeout_hit_s;
    logic          flush_req_s;
    logic          emit_s;
    logic          pend_next_s;
    logic [DW-1:0] lanes_s;
    logic [WW-1:0] word_s;

    // in_ready depends only on the FIFO's registered almost-full, never on in_valid.
    assign bus.in_ready = !bus.full;
    assign bus.we       = we_r;
    assign bus.wr_data  = wr_data_r;

    // Accept, completion and flush-emit decisions for this cycle.
    always_comb begin
        accept_s      = bus.in_valid && !bus.full;
        complete_s    = accept_s && ((lane_r == LANE_MAX) || bus.in_last);
        timeout_hit_s = (TIMEOUT != 16'd0) && (timer_r == TIMEOUT);
        flush_req_s   = flush_pend_r || bus.flush || timeout_hit_s;
        emit_s        = flush_req_s && (lane_r != LANE_ZERO) && !accept_s && !bus.full;
    end

    // Held lanes below the index, the incoming lane at the index, zeros above.
    always_comb begin
        lanes_s = {DW{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) < lane_r) begin
                lanes_s[i*IN_WIDTH +: IN_WIDTH] = hold_r[i*IN_WIDTH +: IN_WIDTH];
            end else if ((CW'(i) == lane_r) && accept_s) begin
                lanes_s[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
            end else begin
                lanes_s[i*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{1'b0}};
            end
        end
    end

    // Outgoing word: a completing accept counts itself, a flush counts held lanes only.
    always_comb begin
        word_s                  = {WW{1'b0}};
        word_s[DATA_LSB +: DW]  = lanes_s;
        if (complete_s) begin
            word_s[LAST_BIT]       = bus.in_last;
            word_s[CNT_LSB +: CW]  = lane_r;
        end else begin
            word_s[LAST_BIT]       = 1'b0;
            word_s[CNT_LSB +: CW]  = lane_r - CW'(1);
        end
    end

    // Pending flush: a completing word absorbs it; an empty word cancels it.
    always_comb begin
        pend_next_s = flush_pend_r;
        if (complete_s) begin
            pend_next_s = 1'b0;
        end else if (accept_s) begin
            pend_next_s = flush_pend_r || bus.flush;
        end else if (lane_r == LANE_ZERO) begin
            pend_next_s = 1'b0;
        end else if (emit_s) begin
            pend_next_s = 1'b0;
        end else begin
            pend_next_s = flush_pend_r || bus.flush;
        end
    end

    // Lane index, holding register, idle timer and pending-flush state.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            lane_r       <= LANE_ZERO;
            hold_r       <= {DW{1'b0}};
            timer_r      <= 16'd0;
            flush_pend_r <= 1'b0;
        end else begin
            flush_pend_r <= pend_next_s;
            if (complete_s || emit_s) begin
                lane_r  <= LANE_ZERO;
                hold_r  <= {DW{1'b0}};
                timer_r <= 16'd0;
            end else if (accept_s) begin
                lane_r  <= lane_r + CW'(1);
                hold_r  <= lanes_s;
                timer_r <= 16'd0;
            end else if ((lane_r != LANE_ZERO) && (timer_r != TIMEOUT)) begin
                timer_r <= timer_r + 16'd1;
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Registered FIFO write port; wr_data keeps the last word between pulses.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            we_r      <= 1'b0;
            wr_data_r <= {WW{1'b0}};
        end else if (complete_s || emit_s) begin
            we_r      <= 1'b1;
            wr_data_r <= word_s;
        end else begin
            we_r      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_pack_writer.sv
// Randomised and directed stimulus for fifo_pack_writer, checked by a
// lane-queue reference model feeding a cycle-stamped scoreboard.
module tb_fifo_pack_writer;

    localparam int IW = 8;
    localparam int R  = 4;
    localparam int TO = 8;
    localparam int WW = R * IW + 2 + 1;

    typedef struct {
        logic [WW-1:0] word;
        int            cyc;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_l = 1'b0;

    fifo_pack_writer_if #(.IN_WIDTH(IW), .RATIO(R)) bus ();

    fifo_pack_writer #(
        .IN_WIDTH (IW),
        .RATIO    (R),
        .TIMEOUT  (16'd8)
    ) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t          exp_q[$];
    logic [7:0]    cur[$];
    bit            pend;
    int            idle;
    int            checks;
    int            errors;
    int            wr_count;
    logic [WW-1:0] last_word;

    // Reference: a word is the list of accepted lanes, closed by size, last, flush or idleness.
    task automatic push_word(input logic last);
        logic [31:0] lanes;
        logic [1:0]  cnt;
        exp_t        e;
        lanes = 32'h0;
        for (int i = 0; i < cur.size(); i++) lanes[i*8 +: 8] = cur[i];
        cnt    = 2'(cur.size() - 1);
        e.word = {last, cnt, lanes};
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        cur.delete();
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic l,
                              input logic f, input logic fu);
        if (v && !fu) begin
            cur.push_back(d);
            idle = 0;
            if (cur.size() == R || l) begin
                push_word(l);
                pend = 1'b0;
            end else begin
                pend = pend | f;
            end
        end else if (cur.size() == 0) begin
            pend = 1'b0;
        end else if ((pend || f || idle == TO) && !fu) begin
            push_word(1'b0);
            pend = 1'b0;
            idle = 0;
        end else begin
            pend = pend | f;
            if (idle < TO) idle++;
        end
    endtask

    task automatic model_reset();
        cur.delete();
        pend = 1'b0;
        idle = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic f, input logic fu);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.flush    = f;
        bus.full     = fu;
        model_edge(v, d, l, f, fu);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_dir(input string name, input int base, input int n,
                             input logic [WW-1:0] w);
        checks++;
        if ((wr_count - base) != n || (n > 0 && last_word !== w)) begin
            errors++;
            $display("FAIL %s: got %0d writes last=%h, want %0d writes last=%h",
                     name, wr_count - base, last_word, n, w);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_l) begin
                checks++;
                if (bus.in_ready !== ~bus.full) begin
                    errors++;
                    $display("FAIL in_ready: got %b want %b at cycle %0d",
                             bus.in_ready, ~bus.full, cyc);
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_write: got no write, want %h at cycle %0d", e.word, e.cyc);
                end
                if (bus.we === 1'b1) begin
                    wr_count++;
                    last_word = bus.wr_data;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: got %h, want no write at cycle %0d",
                                 bus.wr_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.wr_data !== e.word || e.cyc != cyc) begin
                            errors++;
                            $display("FAIL write_data: got %h at cycle %0d, want %h at cycle %0d",
                                     bus.wr_data, cyc, e.word, e.cyc);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int   base;
        logic fu_r;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        bus.flush    = 1'b0;
        bus.full     = 1'b0;
        checks       = 0;
        errors       = 0;
        wr_count     = 0;
        last_word    = '0;
        model_reset();
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.we !== 1'b0 || bus.wr_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got we=%b wr_data=%h, want we=0 wr_data=0", bus.we, bus.wr_data);
        end
        @(posedge clk);
        #1;
        reset_l = 1'b1;

        // Full word of four lanes.
        base = wr_count;
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        idle_n(2);
        check_dir("full_word", base, 1, {1'b0, 2'd3, 32'h44332211});

        // Packet end after two lanes; next packet restarts at lane 0.
        base = wr_count;
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        idle_n(2);
        check_dir("pkt_last", base, 1, {1'b1, 2'd1, 32'h0000BBAA});
        step(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
        idle_n(2);
        check_dir("pkt_restart", base, 2, {1'b1, 2'd0, 32'h000000CC});

        // Explicit flush of three lanes.
        base = wr_count;
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle_n(2);
        check_dir("flush_partial", base, 1, {1'b0, 2'd2, 32'h00030201});

        // Flush with nothing held.
        base = wr_count;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle_n(3);
        check_dir("flush_empty", base, 0, '0);

        // Flush on the completing accept: exactly one write.
        base = wr_count;
        step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC4, 1'b0, 1'b1, 1'b0);
        idle_n(12);
        check_dir("flush_on_complete", base, 1, {1'b0, 2'd3, 32'hC4C3C2C1});

        // Idle timeout on a single lane.
        base = wr_count;
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle_n(9);
        check_dir("timeout_early", base, 0, '0);
        idle_n(1);
        check_dir("timeout_fire", base, 1, {1'b0, 2'd0, 32'h0000005A});

        // An accept part-way through restarts the idle count.
        base = wr_count;
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle_n(4);
        step(1'b1, 8'h6B, 1'b0, 1'b0, 1'b0);
        idle_n(9);
        check_dir("timeout_restart_early", base, 0, '0);
        idle_n(1);
        check_dir("timeout_restart_fire", base, 1, {1'b0, 2'd1, 32'h00006B5A});

        // Almost-full stalls input and defers a flush.
        base = wr_count;
        step(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h73, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h73, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h73, 1'b0, 1'b0, 1'b1);
        check_dir("full_stall", base, 0, '0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_n(1);
        check_dir("full_deferred_flush", base, 1, {1'b0, 2'd1, 32'h00007271});
        step(1'b1, 8'h73, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h74, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h75, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h76, 1'b0, 1'b0, 1'b0);
        idle_n(2);
        check_dir("full_resume", base, 2, {1'b0, 2'd3, 32'h76757473});

        // Reset mid-word discards the partial word.
        step(1'b1, 8'h91, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h92, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h93, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        reset_l      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_l = 1'b1;
        base    = wr_count;
        idle_n(12);
        check_dir("reset_discard", base, 0, '0);
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
        idle_n(2);
        check_dir("reset_new_word", base, 1, {1'b0, 2'd3, 32'hA4A3A2A1});

        // Random traffic with bursty almost-full.
        fu_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99, 0) < 10) fu_r = ~fu_r;
            step(logic'($urandom_range(99, 0) < 70), 8'($urandom),
                 logic'($urandom_range(99, 0) < 15), logic'($urandom_range(99, 0) < 5), fu_r);
        end
        idle_n(20);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d words outstanding, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_pack_writer.md
# fifo_pack_writer

Write-side packer for the team's synchronous FIFOs. Accepts a narrow valid/ready byte-lane stream, gathers up to RATIO lanes into one wide FIFO word tagged with a lane count and an end-of-packet bit, and drives the FIFO write port (`wr_data`/`we`) while honouring the FIFO's registered almost-full (`full`). Partial words are pushed out on packet end, on an explicit flush, or after an idle timeout, so the read end never starves behind a half-filled word.

## Interface
- `IN_WIDTH`, default 8: width of one input lane.
- `RATIO`, default 4: lanes per FIFO word; power of two, at least 2.
- `TIMEOUT`, default 0: idle cycles before a partial word is auto-flushed; 0 disables. 16-bit value.
- `clk`  in  1: clock; all logic on the rising edge.
- `reset_l`  in  1: asynchronous, active-low reset.
- `in_data`  in  IN_WIDTH: input lane data.
- `in_valid`  in  1: `in_data` is valid.
- `in_last`  in  1: the lane is the last of its packet; qualified by `in_valid`.
- `in_ready`  out  1: lane accepted on an edge where `in_valid && in_ready`.
- `flush`  in  1: single-cycle request to emit any partial word.
- `wr_data`  out  RATIO*IN_WIDTH+CW+1: packed word {last, cnt_m1, lanes}. CW = log2(RATIO). Lane 0 is at the LSBs.
- `we`  out  1: FIFO write enable, registered.
- `full`  in  1: FIFO almost-full, registered by the FIFO. At least SLOP ≥ 2 words of margin remain.

## Operation
- State: lane index `lane` (0..RATIO-1), lane holding register, timeout counter `timer` (16 bits), sticky `flush_pend`.
- `in_ready = !full`. There is no combinational path from `in_valid` to `in_ready`.
- Accept: the lane is written into holding position `lane`.
- Word completes on an accept with `lane == RATIO-1` or with `in_last`:
  - Next edge: `we` = 1, `wr_data` = {in_last, lane, holding lanes}.
  - Lanes above `lane` are driven zero.
  - `lane` and the holding register clear.
- Otherwise an accept increments `lane`.
- Flush condition: `flush_pend || flush || (TIMEOUT != 0 && timer == TIMEOUT)`.
  - Honoured only when `lane != 0`, there is no accept this cycle, and `full == 0`.
  - Emits {0, lane-1, held lanes}, then clears `lane`, `timer` and `flush_pend`.
- `flush` arriving while `full`, or on the same cycle as an accept, sets `flush_pend`.
  - If the word completes on that accept, `flush_pend` clears, so exactly one write occurs.
- `flush` or timeout with `lane == 0`: no write; `flush_pend` clears.
- `timer`:
  - Clears on any accept or emit.
  - Increments on each cycle with `lane != 0` and no accept.
  - Saturates at TIMEOUT.
- After `full` rises, at most one further write is issued: a word completed on the edge where `full` rose. This stays within SLOP.

## Timing
- Reset values: `we` = 0, `wr_data` = 0, `lane` = 0, `timer` = 0, `flush_pend` = 0. `in_ready` follows `!full`.
- Latency: one cycle from the completing accept edge (or flush edge) to `we` high. Throughput is one lane per cycle; at most one FIFO write per RATIO cycles under steady input, or per cycle with back-to-back single-lane packets.
- `we` is a single-cycle pulse per word. It is never asserted on a cycle not preceded by a completion or flush event.
- Reset mid-word: the partial word is discarded and no write occurs after `reset_l` rises until new lanes arrive.
- `full` toggling mid-word does not disturb held lanes; accepts resume when `full` drops, with no duplication or loss.

## Structure
- Package `fifo_pack_pkg`:
  - CW computation function.
  - Field offset constants: LAST_BIT, CNT_LSB, DATA_LSB, as functions of IN_WIDTH/RATIO.
  - Shared by the read-side unpacker to decode `wr_data` fields.
- Single module. No sub-module is warranted; the timeout counter stays inline.

## Test plan
- IN_WIDTH=8, RATIO=4: accept 0x11, 0x22, 0x33, 0x44 back-to-back → one cycle after the 4th accept, `we` = 1 for one cycle, `wr_data` = {0, 2'd3, 32'h44332211}.
- Accept 0xAA, then 0xBB with `in_last` → `wr_data` = {1, 2'd1, 32'h0000BBAA}. The next packet starts at lane 0.
- Flush cases:
  - Three lanes 0x01, 0x02, 0x03 then `flush` → {0, 2'd2, 32'h00030201}.
  - `flush` with `lane == 0` → no `we`.
  - `flush` on the accept of the 4th lane → exactly one write.
- TIMEOUT=8: accept one lane 0x5A at edge k, then idle → `we` high after edge k+9 with {0, 2'd0, 32'h0000005A}. An accept at k+5 instead restarts the count.
- Raise `full` after 2 lanes with `in_valid` held → `in_ready` = 0 that cycle; no accepts; a `flush` during `full` is deferred. Drop `full` → the deferred flush emits {0, 2'd1, …} and streaming resumes with no lost lanes.
- Assert `reset_l` low after 3 lanes, release, send 4 new lanes → a single write containing only the new lanes.
